// File: rtl/axil_pkg.sv
// Shared AXI-Lite constants and the read-FSM state type for the register file slice.
package axil_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One-hot encoding leaves 2'b00/2'b11 as detectable illegal states.
    typedef enum logic [1:0] {
        R_IDLE = 2'b01,
        R_DATA = 2'b10
    } rstate_e;

endpackage

// File: rtl/axil_read_ctrl.sv
// AXI-Lite read-channel FSM: registered arready/rvalid plus a load strobe for the read data register.
module axil_read_ctrl
    import axil_pkg::*;
(
    input  logic clk,
    input  logic aresetn,
    input  logic arvalid,
    input  logic rready,
    output logic arready,
    output logic rvalid,
    output logic load
);

    rstate_e state;
    rstate_e state_next;
    logic    arready_d;
    logic    rvalid_d;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state   <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            state   <= state_next;
            arready <= arready_d;
            rvalid  <= rvalid_d;
        end
    end

    // Outputs are the registered image of the next state; illegal states recover with both low.
    always_comb begin
        state_next = state;
        arready_d  = 1'b0;
        rvalid_d   = 1'b0;
        load       = 1'b0;
        case (state)
            R_IDLE: begin
                if (arvalid && arready) begin
                    load       = 1'b1;
                    state_next = R_DATA;
                    rvalid_d   = 1'b1;
                end else begin
                    arready_d  = 1'b1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    state_next = R_IDLE;
                    arready_d  = 1'b1;
                end else begin
                    rvalid_d   = 1'b1;
                end
            end
            default: begin
                state_next = R_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/axil_reg_file.sv
// AXI-Lite register file: byte-strobed write path from held AW/W data, read path via axil_read_ctrl.
// Define REG_FILE_SLVERR_EN to answer out-of-range reads with SLVERR instead of OKAY.
module axil_reg_file
    import axil_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         awvalid,
    input  logic                         awready,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [STRB_W-1:0]            wstrb,
    input  logic                         reg_file_wr_en,
    input  logic                         arvalid,
    output logic                         arready,
    input  logic [ADDR_W-1:0]            araddr,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic [NUM_REGS*DATA_W-1:0]   regs_q
);

    localparam int unsigned IDX_W = ADDR_W - 2;

`ifdef REG_FILE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [IDX_W-1:0]  held_idx;
    logic [DATA_W-1:0] held_data;
    logic [STRB_W-1:0] held_strb;
    logic [IDX_W-1:0]  ar_idx;
    logic [DATA_W-1:0] rd_word;
    logic              rd_hit;
    logic              load;
    logic              unused_ok;

    // Byte-offset address bits carry no information for word registers.
    assign unused_ok = &{1'b0, awaddr[1:0], araddr[1:0]};
    assign ar_idx    = araddr[ADDR_W-1:2];

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            held_idx  <= '0;
            held_data <= '0;
            held_strb <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (awvalid && awready) begin
                held_idx  <= awaddr[ADDR_W-1:2];
                held_data <= wdata;
                held_strb <= wstrb;
            end
            // An index with no matching register simply writes nothing.
            if (reg_file_wr_en) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (32'(held_idx) == i) begin
                        for (int unsigned b = 0; b < STRB_W; b++) begin
                            if (held_strb[b]) begin
                                regs[i][8*b +: 8] <= held_data[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        rd_hit  = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(ar_idx) == i) begin
                rd_word = regs[i];
                rd_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else if (load) begin
            rdata <= rd_word;
            rresp <= rd_hit ? RESP_OKAY : OOR_RESP;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_q[g*DATA_W +: DATA_W] = regs[g];
    end

    axil_read_ctrl u_read_ctrl (
        .clk     (clk),
        .aresetn (aresetn),
        .arvalid (arvalid),
        .rready  (rready),
        .arready (arready),
        .rvalid  (rvalid),
        .load    (load)
    );

endmodule
